// File: rtl/gaus_pkg.sv
// Shared helpers for the Gaussian kernel accumulator family: width
// derivation and the rounding constant used by the normaliser.
package gaus_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Depth of the adder tree for a given tap count.
  function automatic int calc_d(input int taps);
    return clog2(taps);
  endfunction

  // Width of a single pixel * coefficient product.
  function automatic int calc_pw(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Width of one line sum: product width plus one bit per tree level.
  function automatic int calc_sw(input int taps, input int dw, input int cw);
    return calc_pw(dw, cw) + calc_d(taps);
  endfunction

  // Width of the 2-D accumulator; no growth when a single row is summed.
  function automatic int calc_aw(input int taps, input int dw, input int cw, input int rows);
    return (rows > 1) ? calc_sw(taps, dw, cw) + clog2(rows) : calc_sw(taps, dw, cw);
  endfunction

  // Row counter width, never narrower than one bit.
  function automatic int calc_rcw(input int rows);
    return (rows > 1) ? clog2(rows) : 1;
  endfunction

  // Half an LSB of the shifted result, i.e. the round-half-up bias.
  function automatic logic [63:0] round_const(input int shift);
    return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/gaus_kernel_acc_if.sv
// Line/result bus between the window fetch, the kernel accumulator and the
// downstream pyramid stage.
interface gaus_kernel_acc_if #(
  parameter int TAPS = 7,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16
);
  logic                 clear;
  logic                 start;
  logic [TAPS*DW-1:0]   a;
  logic [TAPS*CW-1:0]   b;
  logic [OW-1:0]        result;
  logic                 finish;
  logic                 overflow;

  modport master (output clear, start, a, b, input result, finish, overflow);
  modport slave  (input clear, start, a, b, output result, finish, overflow);
endinterface

// File: rtl/gaus_adder_tree.sv
// Pipelined binary reduction tree. One register level per halving; an odd
// element at any level is carried through a register, zero-extended, so all
// paths have the same latency. A valid bit travels alongside the data.
module gaus_adder_tree
  import gaus_pkg::*;
#(
  parameter int N  = 7,
  parameter int IW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [N*IW-1:0]           i_data,
  output logic                      o_valid,
  output logic [IW+clog2(N)-1:0]    o_sum
);

  localparam int L = clog2(N);

  // Element count at a given tree level.
  function automatic int nodes_at(input int lvl);
    int c;
    c = N;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of a level inside the flattened node vector.
  function automatic int offs(input int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) o += nodes_at(k) * (IW + k);
    return o;
  endfunction

  localparam int TOT = offs(L + 1);

  // All levels packed back to back; level l holds nodes_at(l) words of IW+l bits.
  logic [TOT-1:0] w_flat;
  logic [L:0]     w_vld;

  assign w_flat[N*IW-1:0] = i_data;
  assign w_vld[0]         = i_valid;

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int NL = nodes_at(l);
    localparam int NP = nodes_at(l - 1);
    localparam int WL = IW + l;
    localparam int WP = IW + l - 1;
    localparam int PO = offs(l - 1);
    localparam int CO = offs(l);

    logic r_vld;

    // Valid bit of this level; clear flushes it so aborted lines vanish.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_vld <= 1'b0;
      else if (i_clear) r_vld <= 1'b0;
      else              r_vld <= w_vld[l-1];
    end

    for (genvar j = 0; j < NL; j++) begin : g_node
      logic [WL-1:0] r_sum;

      if (2 * j + 1 < NP) begin : g_pair
        // Pairwise sum, widened by one bit so nothing is truncated.
        always_ff @(posedge clk)
          r_sum <= WL'(w_flat[PO + (2*j)*WP +: WP]) + WL'(w_flat[PO + (2*j+1)*WP +: WP]);
      end else begin : g_pass
        // Unpaired element: delay one level to stay aligned with its peers.
        always_ff @(posedge clk)
          r_sum <= WL'(w_flat[PO + (2*j)*WP +: WP]);
      end

      assign w_flat[CO + j*WL +: WL] = r_sum;
    end

    assign w_vld[l] = r_vld;
  end

  assign o_sum   = w_flat[offs(L) +: IW + L];
  assign o_valid = w_vld[L];

endmodule

// File: rtl/gaus_kernel_acc.sv
// 2-D Gaussian kernel accumulator: per-line dot product of pixels and
// coefficients through a registered multiplier stage and a pipelined adder
// tree, ROWS line sums accumulated into one kernel sum, then rounded
// (half-up), right-shifted and saturated to OW bits.
module gaus_kernel_acc
  import gaus_pkg::*;
#(
  parameter int TAPS  = 7,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int ROWS  = 7,
  parameter int SHIFT = 8,
  parameter int OW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  gaus_kernel_acc_if.slave   io_bus
);

  localparam int PW  = calc_pw(DW, CW);
  localparam int SW  = calc_sw(TAPS, DW, CW);
  localparam int AW  = calc_aw(TAPS, DW, CW, ROWS);
  localparam int RCW = calc_rcw(ROWS);
  // Wide enough to hold both the rounded sum and the OW-bit ceiling.
  localparam int XW  = (AW + 1 > OW) ? AW + 1 : OW + 1;

  localparam logic [AW:0]    RND      = (AW + 1)'(round_const(SHIFT));
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  logic [TAPS*PW-1:0] r_prod;
  logic               r_prod_vld;
  logic [SW-1:0]      w_line;
  logic               w_line_vld;
  logic [AW-1:0]      r_acc;
  logic [AW-1:0]      w_full;
  logic [RCW-1:0]     r_row_cnt;
  logic [AW:0]        w_rnd;
  logic [XW-1:0]      w_rnd_x;
  logic               w_sat;
  logic [OW-1:0]      w_res;
  logic [OW-1:0]      r_result;
  logic               r_finish;
  logic               r_overflow;

  // Product-stage valid: a start that coincides with clear is dropped.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prod_vld <= 1'b0;
    else        r_prod_vld <= io_bus.start & ~io_bus.clear;
  end

  // One registered multiplier per tap, full-width products.
  // NOTE: pure datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++)
      r_prod[i*PW +: PW] <= PW'(io_bus.a[i*DW +: DW]) * PW'(io_bus.b[i*CW +: CW]);
  end

  gaus_adder_tree #(
    .N  (TAPS),
    .IW (PW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (io_bus.clear),
    .i_valid (r_prod_vld),
    .i_data  (r_prod),
    .o_valid (w_line_vld),
    .o_sum   (w_line)
  );

  // Kernel sum including the arriving line, then round, shift and saturate.
  assign w_full  = r_acc + AW'(w_line);
  assign w_rnd   = ({1'b0, w_full} + RND) >> SHIFT;
  assign w_rnd_x = XW'(w_rnd);
  assign w_sat   = |(w_rnd_x >> OW);
  assign w_res   = w_sat ? {OW{1'b1}} : OW'(w_rnd);

  // Row accumulation; the terminal row emits the result and restarts the kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_row_cnt  <= '0;
      r_result   <= '0;
      r_finish   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_finish   <= 1'b0;
      r_overflow <= 1'b0;
      if (io_bus.clear) begin
        r_acc     <= '0;
        r_row_cnt <= '0;
      end else if (w_line_vld) begin
        if (r_row_cnt != LAST_ROW) begin
          r_acc     <= w_full;
          r_row_cnt <= r_row_cnt + RCW'(1);
        end else begin
          r_acc      <= '0;
          r_row_cnt  <= '0;
          r_result   <= w_res;
          r_finish   <= 1'b1;
          r_overflow <= w_sat;
        end
      end
    end
  end

  assign io_bus.result   = r_result;
  assign io_bus.finish   = r_finish;
  assign io_bus.overflow = r_overflow;

endmodule

// File: tb/tb_gaus_kernel_acc.sv
// Bench for gaus_kernel_acc: a default-parameter unit checked every cycle
// against a line-level reference model, plus a ROWS=1/SHIFT=0 unit checked
// line by line.
module tb_gaus_kernel_acc;

  localparam int TAPS = 7;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 16;
  localparam int ROWS = 7;
  localparam int SHIFT = 8;
  localparam int D    = 3;        // tree depth for 7 taps
  localparam int LAT  = D + 2;    // start cycle -> finish cycle
  localparam int MAXC = 8192;
  localparam longint OMAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gaus_kernel_acc_if #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) bus0 ();
  gaus_kernel_acc_if #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) bus1 ();

  gaus_kernel_acc #(
    .TAPS(TAPS), .DW(DW), .CW(CW), .ROWS(ROWS), .SHIFT(SHIFT), .OW(OW)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus0)
  );

  gaus_kernel_acc #(
    .TAPS(TAPS), .DW(DW), .CW(CW), .ROWS(1), .SHIFT(0), .OW(OW)
  ) u_single (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus log, indexed by the cycle in which the inputs were presented.
  bit     line_vld [MAXC];
  longint line_sum [MAXC];
  bit     clr_at   [MAXC];

  // Reference model state.
  longint      m_acc    = 0;
  int          m_rows   = 0;
  logic [15:0] m_result = '0;

  // Observed finish pulses, for the directed checks.
  int          fin_count = 0;
  int          fin_cyc [$];
  logic [15:0] last_res;
  logic        last_ovf;

  logic [55:0] gauss_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint dot(input logic [55:0] av, input logic [55:0] bv);
    longint s;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(av[i*8 +: 8]) * longint'(bv[i*8 +: 8]);
    return s;
  endfunction

  function automatic logic [55:0] fill(input logic [7:0] v);
    return {7{v}};
  endfunction

  function automatic logic [55:0] rnd56();
    return 56'({$urandom(), $urandom()});
  endfunction

  // Reference model and per-cycle comparison for the default unit. A line
  // presented in cycle k is folded in at cycle k+LAT; a clear presented in
  // cycle c empties the kernel and kills every line still in flight.
  always @(negedge clk) begin : p_mon
    bit     exp_fin;
    bit     exp_ovf;
    longint r;
    int     k;
    exp_fin = 1'b0;
    exp_ovf = 1'b0;
    if (!rst_n) begin
      m_acc    = 0;
      m_rows   = 0;
      m_result = '0;
      for (int j = cyc - LAT; j < cyc; j++) if (j >= 0 && j < MAXC) line_vld[j] = 1'b0;
    end else if (cyc < MAXC) begin
      if (cyc >= 1 && clr_at[cyc-1]) begin
        m_acc  = 0;
        m_rows = 0;
        for (int j = cyc - 1 - (D + 1); j <= cyc - 1; j++) if (j >= 0) line_vld[j] = 1'b0;
      end
      k = cyc - LAT;
      if (k >= 0 && line_vld[k]) begin
        m_acc += line_sum[k];
        m_rows++;
        if (m_rows == ROWS) begin
          r        = (m_acc + (longint'(1) << (SHIFT - 1))) >> SHIFT;
          exp_ovf  = (r > OMAX);
          m_result = exp_ovf ? 16'hFFFF : r[15:0];
          exp_fin  = 1'b1;
          m_acc    = 0;
          m_rows   = 0;
        end
      end
    end
    total++;
    if (bus0.finish !== exp_fin) begin
      bad++;
      $display("FAIL finish @%0d: got %b expected %b", cyc, bus0.finish, exp_fin);
    end
    if (bus0.finish === 1'b1) begin
      fin_count++;
      fin_cyc.push_back(cyc);
      last_res = bus0.result;
      last_ovf = bus0.overflow;
    end
    total++;
    if (bus0.overflow !== exp_ovf) begin
      bad++;
      $display("FAIL overflow @%0d: got %b expected %b", cyc, bus0.overflow, exp_ovf);
    end
    total++;
    if (bus0.result !== m_result) begin
      bad++;
      $display("FAIL result @%0d: got %0d expected %0d", cyc, bus0.result, m_result);
    end
  end

  // Present one cycle of inputs to the default unit and log them.
  task automatic drive(input bit st, input bit clr, input logic [55:0] av, input logic [55:0] bv);
    bus0.start = st;
    bus0.clear = clr;
    bus0.a     = av;
    bus0.b     = bv;
    if (cyc < MAXC) begin
      line_vld[cyc] = st && !clr;
      line_sum[cyc] = dot(av, bv);
      clr_at[cyc]   = clr;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, rnd56(), rnd56());
  endtask

  // Seven consecutive lines of one pattern, then drain; exactly one finish.
  task automatic run_kernel(input logic [55:0] av, input logic [55:0] bv,
                            input longint exp_res, input bit exp_o, input string tag);
    int n0;
    int s_last;
    n0 = fin_count;
    s_last = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (i == ROWS - 1) s_last = cyc;
      drive(1'b1, 1'b0, av, bv);
    end
    idle(10);
    total++;
    if (fin_count - n0 != 1) begin
      bad++;
      $display("FAIL %s finish count: got %0d expected 1", tag, fin_count - n0);
    end
    total++;
    if (fin_cyc.size() == 0 || fin_cyc[fin_cyc.size()-1] - s_last != LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", tag,
               (fin_cyc.size() == 0) ? -1 : fin_cyc[fin_cyc.size()-1] - s_last, LAT);
    end
    total++;
    if (longint'(last_res) != exp_res) begin
      bad++;
      $display("FAIL %s result: got %0d expected %0d", tag, last_res, exp_res);
    end
    total++;
    if (last_ovf !== exp_o) begin
      bad++;
      $display("FAIL %s overflow: got %b expected %b", tag, last_ovf, exp_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus0.result !== 16'd0 || bus0.finish !== 1'b0 || bus0.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: got %0d/%b/%b expected 0/0/0", bus0.result, bus0.finish, bus0.overflow);
    end
    total++;
    if (bus1.result !== 16'd0 || bus1.finish !== 1'b0) begin
      bad++;
      $display("FAIL reset single outputs: got %0d/%b expected 0/0", bus1.result, bus1.finish);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gauss();
    run_kernel(fill(8'd100), gauss_b, 175, 1'b0, "gauss");
  endtask

  task automatic test_max();
    run_kernel(fill(8'd255), fill(8'd255), 12446, 1'b0, "max");
  endtask

  // ROWS=1, SHIFT=0 unit: every line is a result, saturated to 16 bits.
  task automatic test_single_line();
    logic [55:0] la [10];
    logic [55:0] lb [10];
    longint      ex [10];
    bit          ef;
    la[0] = fill(8'd255); lb[0] = fill(8'd255);
    la[1] = fill(8'd1);   lb[1] = fill(8'd1);
    for (int i = 2; i < 10; i++) begin
      la[i] = rnd56();
      lb[i] = (i % 2 == 0) ? rnd56() : fill(8'd3);
    end
    for (int i = 0; i < 10; i++) ex[i] = dot(la[i], lb[i]);
    for (int i = 0; i < 16; i++) begin
      ef = (i >= LAT) && (i - LAT < 10);
      total++;
      if (bus1.finish !== ef) begin
        bad++;
        $display("FAIL single finish step %0d: got %b expected %b", i, bus1.finish, ef);
      end
      if (ef) begin
        total++;
        if (longint'(bus1.result) != ((ex[i-LAT] > OMAX) ? OMAX : ex[i-LAT])) begin
          bad++;
          $display("FAIL single result line %0d: got %0d expected %0d", i - LAT, bus1.result,
                   (ex[i-LAT] > OMAX) ? OMAX : ex[i-LAT]);
        end
        total++;
        if (bus1.overflow !== (ex[i-LAT] > OMAX)) begin
          bad++;
          $display("FAIL single overflow line %0d: got %b expected %b", i - LAT, bus1.overflow, ex[i-LAT] > OMAX);
        end
      end
      bus1.start = (i < 10);
      bus1.a     = (i < 10) ? la[i] : '0;
      bus1.b     = (i < 10) ? lb[i] : '0;
      @(negedge clk);
    end
    bus1.start = 1'b0;
  endtask

  // 14 back-to-back lines, then 7 lines separated by random bubbles.
  task automatic test_back_to_back();
    int n0;
    int q0;
    n0 = fin_count;
    q0 = fin_cyc.size();
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, rnd56(), rnd56());
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, rnd56(), rnd56());
      if ($urandom_range(1, 0) == 1) idle(1);
    end
    idle(10);
    total++;
    if (fin_count - n0 != 3) begin
      bad++;
      $display("FAIL b2b finish count: got %0d expected 3", fin_count - n0);
    end
    total++;
    if (fin_cyc.size() < q0 + 2 || fin_cyc[q0+1] - fin_cyc[q0] != 7) begin
      bad++;
      $display("FAIL b2b spacing: got %0d expected 7",
               (fin_cyc.size() < q0 + 2) ? -1 : fin_cyc[q0+1] - fin_cyc[q0]);
    end
  endtask

  // Three lines aborted by a clear that also carries a start.
  task automatic test_clear();
    int n0;
    n0 = fin_count;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, fill(8'd200), gauss_b);
    drive(1'b1, 1'b1, fill(8'd200), gauss_b);
    run_kernel(fill(8'd100), gauss_b, 175, 1'b0, "clear");
    total++;
    if (fin_count - n0 != 1) begin
      bad++;
      $display("FAIL clear total finishes: got %0d expected 1", fin_count - n0);
    end
  endtask

  // Asynchronous reset after four lines of a kernel.
  task automatic test_async_reset();
    run_kernel(fill(8'd100), gauss_b, 175, 1'b0, "pre_reset");
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, fill(8'd200), fill(8'd200));
    bus0.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus0.result !== 16'd0 || bus0.finish !== 1'b0 || bus0.overflow !== 1'b0) begin
      bad++;
      $display("FAIL async reset outputs: got %0d/%b/%b expected 0/0/0", bus0.result, bus0.finish, bus0.overflow);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_kernel(fill(8'd100), gauss_b, 175, 1'b0, "post_reset");
  endtask

  // Random lines, bubbles and occasional clears against the model.
  task automatic test_random();
    int r;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(99, 0);
      if (r < 3)       drive(1'b1, 1'b1, rnd56(), rnd56());
      else if (r < 25) drive(1'b0, 1'b0, rnd56(), rnd56());
      else if (r < 35) drive(1'b1, 1'b0, fill(8'd255), fill(8'd255));
      else             drive(1'b1, 1'b0, rnd56(), rnd56());
    end
    idle(12);
  endtask

  initial begin
    gauss_b    = {8'd1, 8'd6, 8'd15, 8'd20, 8'd15, 8'd6, 8'd1};
    bus0.clear = 1'b0;
    bus0.start = 1'b0;
    bus0.a     = '0;
    bus0.b     = '0;
    bus1.clear = 1'b0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    last_res   = '0;
    last_ovf   = 1'b0;
    test_reset();
    test_gauss();
    test_max();
    test_single_line();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
